pipe_hazard_ctrl: RTL and testbench

//  Central pipeline control for the 5-stage Y86-64 core. Sequences the F/D/E/M/W pipeline registers by

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage Y86-64 core: per-stage stall/bubble generation,
// run/step/halt sequencing and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [3:0]       D_in_code,
    input  logic [3:0]       d_src_a,
    input  logic [3:0]       d_src_b,
    input  logic [3:0]       E_in_code,
    input  logic [3:0]       E_dst_m,
    input  logic             e_cnd,
    input  logic [3:0]       M_in_code,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_in_code,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bub,
    output logic             E_bub,
    output logic             M_bub,
    output logic             W_stall,
    output logic             halted,
    output logic [1:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    localparam logic [3:0] ICodeNop    = 4'd1;
    localparam logic [3:0] ICodeMrmovq = 4'd5;
    localparam logic [3:0] ICodeJxx    = 4'd7;
    localparam logic [3:0] ICodeRet    = 4'd9;
    localparam logic [3:0] ICodePopq   = 4'd11;
    localparam logic [3:0] RegNone     = 4'hF;

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cpu_stat_q, cpu_stat_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

    logic lu, rt, mp, ex, active;

    always_comb begin
        lu = ((E_in_code == ICodeMrmovq) || (E_in_code == ICodePopq)) &&
             (E_dst_m != RegNone) && ((E_dst_m == d_src_a) || (E_dst_m == d_src_b));
        rt = (D_in_code == ICodeRet) || (E_in_code == ICodeRet) || (M_in_code == ICodeRet);
        mp = (E_in_code == ICodeJxx) && !e_cnd;
        ex = (m_stat != 2'd0) || (W_stat != 2'd0);
    end

    assign active = (state_q == StRun) || (state_q == StStep);

    // Hazard outputs; a misprediction squashes D, so it overrides a load/use stall.
    always_comb begin
        F_stall = lu | rt;
        D_stall = lu & ~mp;
        D_bub   = mp | (rt & ~lu);
        E_bub   = mp | lu;
        M_bub   = ex;
        W_stall = (W_stat != 2'd0);
        unique case (state_q)
            StIdle: begin
                F_stall = 1'b1;
                D_stall = 1'b0;
                D_bub   = 1'b1;
                E_bub   = 1'b1;
                M_bub   = 1'b1;
                W_stall = 1'b0;
            end
            StStep: begin
                if (!step) begin
                    F_stall = 1'b1;
                    D_bub   = D_bub | ~D_stall;
                end
            end
            StHalted: begin
                F_stall = 1'b1;
                D_stall = 1'b0;
                D_bub   = 1'b1;
                E_bub   = 1'b1;
                M_bub   = 1'b1;
                W_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = step_mode ? StStep : StRun;
                end
            end
            StRun, StStep: begin
                if (W_stat != 2'd0) begin
                    state_d    = StHalted;
                    cpu_stat_d = W_stat;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        bub_cnt_d = bub_cnt_q;
        if (active) begin
            if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
            if ((W_in_code != ICodeNop) && (W_stat == 2'd0) && (ret_cnt_q != '1)) begin
                ret_cnt_d = ret_cnt_q + CNT_W'(1);
            end
            if (E_bub && (bub_cnt_q != '1)) bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cpu_stat_q <= 2'd0;
            cyc_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            bub_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
            cyc_cnt_q  <= cyc_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            bub_cnt_q  <= bub_cnt_d;
        end
    end

    assign halted   = (state_q == StHalted);
    assign cpu_stat = cpu_stat_q;
    assign cyc_cnt  = cyc_cnt_q;
    assign ret_cnt  = ret_cnt_q;
    assign bub_cnt  = bub_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with 2-bit counters
// exercises counter saturation on the same stimulus.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, step_mode, step;
    logic [3:0]  D_in_code, d_src_a, d_src_b, E_in_code, E_dst_m, M_in_code, W_in_code;
    logic        e_cnd;
    logic [1:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bub, E_bub, M_bub, W_stall, halted;
    logic [1:0]  cpu_stat;
    logic [31:0] cyc_cnt, ret_cnt, bub_cnt;
    logic        s_f_stall, s_d_stall, s_d_bub, s_e_bub, s_m_bub, s_w_stall, s_halted;
    logic [1:0]  s_cpu_stat, s_cyc, s_ret, s_bub;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
        .D_in_code(D_in_code), .d_src_a(d_src_a), .d_src_b(d_src_b), .E_in_code(E_in_code),
        .E_dst_m(E_dst_m), .e_cnd(e_cnd), .M_in_code(M_in_code), .m_stat(m_stat),
        .W_stat(W_stat), .W_in_code(W_in_code), .F_stall(F_stall), .D_stall(D_stall),
        .D_bub(D_bub), .E_bub(E_bub), .M_bub(M_bub), .W_stall(W_stall), .halted(halted),
        .cpu_stat(cpu_stat), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .bub_cnt(bub_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .start(start), .step_mode(step_mode), .step(step),
        .D_in_code(D_in_code), .d_src_a(d_src_a), .d_src_b(d_src_b), .E_in_code(E_in_code),
        .E_dst_m(E_dst_m), .e_cnd(e_cnd), .M_in_code(M_in_code), .m_stat(m_stat),
        .W_stat(W_stat), .W_in_code(W_in_code), .F_stall(s_f_stall), .D_stall(s_d_stall),
        .D_bub(s_d_bub), .E_bub(s_e_bub), .M_bub(s_m_bub), .W_stall(s_w_stall),
        .halted(s_halted), .cpu_stat(s_cpu_stat), .cyc_cnt(s_cyc), .ret_cnt(s_ret),
        .bub_cnt(s_bub)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        D_in_code = 4'd1; E_in_code = 4'd1; M_in_code = 4'd1; W_in_code = 4'd1;
        d_src_a = 4'hF; d_src_b = 4'hF; E_dst_m = 4'hF; e_cnd = 1'b1;
        m_stat = 2'd0; W_stat = 2'd0;
    endtask

    task automatic chk_haz(input string tag, input logic [5:0] exp);
        #1;
        check({tag, " F/D/Db/Eb/Mb/W"}, {26'd0, F_stall, D_stall, D_bub, E_bub, M_bub, W_stall},
              {26'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int cyc, input int ret, input int bub);
        check({tag, " cyc"}, cyc_cnt, cyc);
        check({tag, " ret"}, ret_cnt, ret);
        check({tag, " bub"}, bub_cnt, bub);
    endtask

    initial begin
        start = 1'b0; step_mode = 1'b0; step = 1'b0;
        quiet();
        reset_n = 1'b0;
        #12;
        // Reset / IDLE
        chk_haz("idle", 6'b101110);
        check("rst halted", {31'd0, halted}, 32'd0);
        check("rst cpu_stat", {30'd0, cpu_stat}, 32'd0);
        chk_cnt("rst", 0, 0, 0);
        tick();
        chk_cnt("idle frozen", 0, 0, 0);
        reset_n = 1'b1;

        // Start in RUN mode
        start = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        check("run halted", {31'd0, halted}, 32'd0);
        chk_haz("run clean", 6'b000000);
        chk_cnt("run start", 0, 0, 0);
        tick();
        chk_cnt("run 1", 1, 0, 0);
        check("sat cyc 1", {30'd0, s_cyc}, 32'd1);

        // Load/use
        E_in_code = 4'd5; E_dst_m = 4'd3; d_src_a = 4'd3;
        chk_haz("lu", 6'b110100);
        E_in_code = 4'd11; d_src_a = 4'hF; d_src_b = 4'd3;
        chk_haz("lu popq srcb", 6'b110100);
        E_dst_m = 4'hF; d_src_b = 4'hF;
        chk_haz("no lu dst none", 6'b000000);
        E_in_code = 4'd5; E_dst_m = 4'd3; d_src_a = 4'd3;
        tick();
        chk_cnt("lu", 2, 0, 1);

        // Load/use plus ret: D stalls, no D bubble
        D_in_code = 4'd9;
        chk_haz("lu+ret", 6'b110100);
        quiet();

        // ret moving through D, E, M
        D_in_code = 4'd9;
        chk_haz("ret D", 6'b101000);
        tick();
        D_in_code = 4'd1; E_in_code = 4'd9;
        chk_haz("ret E", 6'b101000);
        tick();
        E_in_code = 4'd1; M_in_code = 4'd9;
        chk_haz("ret M", 6'b101000);
        tick();
        quiet();
        chk_cnt("ret", 5, 0, 1);

        // Mispredicted jump with matching sources
        E_in_code = 4'd7; e_cnd = 1'b0; E_dst_m = 4'd3; d_src_a = 4'd3;
        chk_haz("mp", 6'b001100);
        e_cnd = 1'b1;
        chk_haz("jxx taken", 6'b000000);
        e_cnd = 1'b0;
        tick();
        quiet();
        chk_cnt("mp", 6, 0, 2);

        // Retire one real instruction
        W_in_code = 4'd6;
        tick();
        W_in_code = 4'd1;
        chk_cnt("retire", 7, 1, 2);

        // Exception drain then halt
        m_stat = 2'd2;
        chk_haz("m_stat", 6'b000010);
        tick();
        check("m_stat no halt", {31'd0, halted}, 32'd0);
        m_stat = 2'd0; W_stat = 2'd2;
        chk_haz("W_stat", 6'b000011);
        tick();
        check("halted", {31'd0, halted}, 32'd1);
        check("cpu_stat", {30'd0, cpu_stat}, 32'd2);
        chk_cnt("halt", 9, 1, 2);
        check("sat cyc", {30'd0, s_cyc}, 32'd3);
        W_stat = 2'd0; W_in_code = 4'd6; E_in_code = 4'd5; E_dst_m = 4'd3; d_src_a = 4'd3;
        start = 1'b1;
        chk_haz("halted outs", 6'b101111);
        repeat (3) tick();
        start = 1'b0;
        check("stay halted", {31'd0, halted}, 32'd1);
        chk_cnt("frozen", 9, 1, 2);
        quiet();

        // Asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        check("rst2 halted", {31'd0, halted}, 32'd0);
        check("rst2 cpu_stat", {30'd0, cpu_stat}, 32'd0);
        chk_cnt("rst2", 0, 0, 0);
        check("sat rst2", {30'd0, s_cyc}, 32'd0);
        tick();
        reset_n = 1'b1;

        // Step mode
        start = 1'b1; step_mode = 1'b1;
        tick();
        start = 1'b0; step_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("step idle F_stall", {31'd0, F_stall}, 32'd1);
            check("step idle D_bub", {31'd0, D_bub}, 32'd1);
            tick();
        end
        E_in_code = 4'd5; E_dst_m = 4'd3; d_src_a = 4'd3;
        chk_haz("step lu", 6'b110100);
        quiet();
        step = 1'b1;
        chk_haz("step pulse", 6'b000000);
        tick();
        step = 1'b0;
        W_in_code = 4'd6;
        tick();
        W_in_code = 4'd1;
        check("step halted", {31'd0, halted}, 32'd0);
        chk_cnt("step", 12, 1, 0);
        check("sat cyc end", {30'd0, s_cyc}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
